// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: load-use stall, branch flush, EX operand forwarding
// Tracks the EX/MEM/WB occupants so stall, flush and forward decisions need only decode-stage inputs.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_wr_en_i,
    input  logic        id_is_load_i,
    input  logic        br_taken_i,
    input  logic        mem_busy_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        flush_id_o,
    output logic [1:0]  fwd_rs1_o,
    output logic [1:0]  fwd_rs2_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    logic        ex_valid_q, ex_wr_q, ex_load_q, ex_use1_q, ex_use2_q;
    logic [4:0]  ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic        mem_valid_q, mem_wr_q, mem_load_q;
    logic [4:0]  mem_rd_q;
    logic        wb_valid_q, wb_wr_q;
    logic [4:0]  wb_rd_q;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        load_use;
    logic        ex_valid_d;

    assign load_use = id_valid_i & ex_valid_q & ex_load_q & ex_wr_q & (ex_rd_q != 5'd0)
                    & ((id_use_rs1_i & (id_rs1_i == ex_rd_q))
                     | (id_use_rs2_i & (id_rs2_i == ex_rd_q)));

    assign ex_valid_d = id_valid_i & ~load_use & ~br_taken_i;

    // Control outputs are forced low during reset even though mem_busy_i/br_taken_i feed them directly.
    always_comb begin
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        flush_id_o = 1'b0;
        if (rst_n) begin
            if (mem_busy_i) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
            end else if (br_taken_i) begin
                flush_id_o = 1'b1;
            end else if (load_use) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
            end
        end
    end

    // A load still in MEM has no data yet, so it is skipped and WB may supply an older value.
    always_comb begin
        fwd_rs1_o = 2'b00;
        if (ex_valid_q & ex_use1_q & (ex_rs1_q != 5'd0)) begin
            if (mem_valid_q & mem_wr_q & ~mem_load_q & (mem_rd_q == ex_rs1_q))
                fwd_rs1_o = 2'b01;
            else if (wb_valid_q & wb_wr_q & (wb_rd_q == ex_rs1_q))
                fwd_rs1_o = 2'b10;
        end
    end

    always_comb begin
        fwd_rs2_o = 2'b00;
        if (ex_valid_q & ex_use2_q & (ex_rs2_q != 5'd0)) begin
            if (mem_valid_q & mem_wr_q & ~mem_load_q & (mem_rd_q == ex_rs2_q))
                fwd_rs2_o = 2'b01;
            else if (wb_valid_q & wb_wr_q & (wb_rd_q == ex_rs2_q))
                fwd_rs2_o = 2'b10;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_id_o && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_id_o && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            ex_use1_q   <= 1'b0;
            ex_use2_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_wr_q    <= 1'b0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_wr_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (!mem_busy_i) begin
                wb_valid_q  <= mem_valid_q;
                wb_rd_q     <= mem_rd_q;
                wb_wr_q     <= mem_wr_q;
                mem_valid_q <= ex_valid_q;
                mem_rd_q    <= ex_rd_q;
                mem_wr_q    <= ex_wr_q;
                mem_load_q  <= ex_load_q;
                ex_valid_q  <= ex_valid_d;
                ex_rd_q     <= id_rd_i;
                ex_wr_q     <= id_wr_en_i;
                ex_load_q   <= id_is_load_i;
                ex_rs1_q    <= id_rs1_i;
                ex_rs2_q    <= id_rs2_i;
                ex_use1_q   <= id_use_rs1_i;
                ex_use2_q   <= id_use_rs2_i;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against an instruction-list reference model
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid_i, id_use_rs1_i, id_use_rs2_i, id_wr_en_i, id_is_load_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        br_taken_i, mem_busy_i;
    logic        stall_if_o, stall_id_o, flush_id_o;
    logic [1:0]  fwd_rs1_o, fwd_rs2_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i), .id_wr_en_i(id_wr_en_i), .id_is_load_i(id_is_load_i),
        .br_taken_i(br_taken_i), .mem_busy_i(mem_busy_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .flush_id_o(flush_id_o),
        .fwd_rs1_o(fwd_rs1_o), .fwd_rs2_o(fwd_rs2_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       wr, ld;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
    } inst_t;

    typedef struct {
        logic        sif, sid, fl;
        logic [1:0]  f1, f2;
        logic [15:0] sc, fc;
    } exp_t;

    // older[0] = instruction in EX, older[1] = MEM, older[2] = WB
    inst_t older [3];
    int    m_sc, m_fc;
    exp_t  exp_q [$];
    event  sample_ev;
    int    vectors = 0;
    int    miscompares = 0;

    function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic u);
        if (!older[0].v || !u || rs == 5'd0) return 2'b00;
        for (int s = 1; s <= 2; s++) begin
            if (older[s].v && older[s].wr && older[s].rd == rs) begin
                if (s == 1 && older[s].ld) continue;
                return (s == 1) ? 2'b01 : 2'b10;
            end
        end
        return 2'b00;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic u1, input logic u2, input logic [4:0] d, input logic w,
                         input logic l, input logic b, input logic m);
        exp_t  e;
        logic  lu;
        inst_t bubble;
        @(negedge clk);
        rst_n = r; id_valid_i = v; id_rs1_i = s1; id_rs2_i = s2;
        id_use_rs1_i = u1; id_use_rs2_i = u2; id_rd_i = d; id_wr_en_i = w;
        id_is_load_i = l; br_taken_i = b; mem_busy_i = m;
        #1;
        bubble = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
        if (!r) begin
            for (int k = 0; k < 3; k++) older[k] = bubble;
            m_sc = 0;
            m_fc = 0;
        end
        lu = v && older[0].v && older[0].ld && older[0].wr && older[0].rd != 5'd0 &&
             ((u1 && s1 == older[0].rd) || (u2 && s2 == older[0].rd));
        e.sif = 1'b0; e.sid = 1'b0; e.fl = 1'b0;
        if (r) begin
            if (m)       begin e.sif = 1'b1; e.sid = 1'b1; end
            else if (b)  e.fl = 1'b1;
            else if (lu) begin e.sif = 1'b1; e.sid = 1'b1; end
        end
        e.f1 = fwd_model(older[0].rs1, older[0].u1);
        e.f2 = fwd_model(older[0].rs2, older[0].u2);
        e.sc = 16'(m_sc);
        e.fc = 16'(m_fc);
        exp_q.push_back(e);
        -> sample_ev;
        if (r) begin
            if (e.sid && m_sc < 65535) m_sc++;
            if (e.fl && m_fc < 65535) m_fc++;
            if (!m) begin
                older[2] = older[1];
                older[1] = older[0];
                older[0] = '{v && !lu && !b, d, w, l, s1, s2, u1, u2};
            end
        end
    endtask

    task automatic ins(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic w, input logic l, input logic b);
        drive(1'b1, 1'b1, s1, s2, u1, u2, d, w, l, b, 1'b0);
    endtask

    task automatic nop(input logic b, input logic m);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, b, m);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", n, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            e = exp_q.pop_front();
            vectors++;
            if (stall_if_o !== e.sif || stall_id_o !== e.sid || flush_id_o !== e.fl ||
                fwd_rs1_o !== e.f1 || fwd_rs2_o !== e.f2 ||
                stall_cnt_o !== e.sc || flush_cnt_o !== e.fc) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t: got sif=%b sid=%b fl=%b f1=%b f2=%b sc=%h fc=%h required sif=%b sid=%b fl=%b f1=%b f2=%b sc=%h fc=%h",
                         $time, stall_if_o, stall_id_o, flush_id_o, fwd_rs1_o, fwd_rs2_o,
                         stall_cnt_o, flush_cnt_o, e.sif, e.sid, e.fl, e.f1, e.f2, e.sc, e.fc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0;
        id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; id_rd_i = '0; id_wr_en_i = 1'b0;
        id_is_load_i = 1'b0; br_taken_i = 1'b0; mem_busy_i = 1'b0;

        do_reset();
        chk("reset_stall_id", 16'(stall_id_o), 16'd0);
        chk("reset_fwd1", 16'(fwd_rs1_o), 16'd0);

        // lw x5 ; add x6,x5,x7
        ins(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        ins(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_stall_if", 16'(stall_if_o), 16'd1);
        chk("lu_stall_id", 16'(stall_id_o), 16'd1);
        ins(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lu_one_cycle", 16'(stall_id_o), 16'd0);
        nop(1'b0, 1'b0);
        chk("lu_fwd_rs1", 16'(fwd_rs1_o), 16'd2);
        chk("lu_stall_cnt", stall_cnt_o, 16'd1);

        // add x3,x1,x2 ; sub x4,x3,x3
        do_reset();
        ins(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ins(5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("alu_no_stall", 16'(stall_id_o), 16'd0);
        nop(1'b0, 1'b0);
        chk("alu_mem_fwd1", 16'(fwd_rs1_o), 16'd1);
        chk("alu_mem_fwd2", 16'(fwd_rs2_o), 16'd1);

        do_reset();
        ins(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ins(5'd9, 5'd10, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ins(5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        nop(1'b0, 1'b0);
        chk("alu_wb_fwd1", 16'(fwd_rs1_o), 16'd2);
        chk("alu_wb_fwd2", 16'(fwd_rs2_o), 16'd2);

        // lw x0 ; add x1,x0,x0
        do_reset();
        ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        ins(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("x0_no_stall", 16'(stall_id_o), 16'd0);
        nop(1'b0, 1'b0);
        chk("x0_fwd1", 16'(fwd_rs1_o), 16'd0);
        chk("x0_fwd2", 16'(fwd_rs2_o), 16'd0);

        // taken branch coinciding with a load-use condition
        do_reset();
        ins(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        ins(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("br_flush", 16'(flush_id_o), 16'd1);
        chk("br_no_stall", 16'(stall_id_o), 16'd0);
        nop(1'b0, 1'b0);
        chk("br_flush_cnt", flush_cnt_o, 16'd1);

        // freeze with a held taken branch
        do_reset();
        for (int i = 0; i < 3; i++) begin
            nop(1'b1, 1'b1);
            chk("frz_stall_if", 16'(stall_if_o), 16'd1);
            chk("frz_no_flush", 16'(flush_id_o), 16'd0);
        end
        nop(1'b1, 1'b0);
        chk("frz_flush", 16'(flush_id_o), 16'd1);
        chk("frz_stall_cnt", stall_cnt_o, 16'd3);

        // randomized traffic over a small register set so hazards are frequent
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) != 0), 1'(($urandom_range(3) != 0)),
                  5'($urandom_range(3)), 5'($urandom_range(3)),
                  1'($urandom_range(1)), 1'($urandom_range(1)),
                  5'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'(($urandom_range(9) == 0)), 1'(($urandom_range(4) == 0)));
        end

        // counter saturation, then reset mid-freeze
        do_reset();
        for (int i = 0; i < 70000; i++) nop(1'b0, 1'b1);
        chk("sat_stall_cnt", stall_cnt_o, 16'hFFFF);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_stall_if", 16'(stall_if_o), 16'd0);
        chk("rst_stall_id", 16'(stall_id_o), 16'd0);
        chk("rst_flush", 16'(flush_id_o), 16'd0);
        chk("rst_stall_cnt", stall_cnt_o, 16'd0);
        chk("rst_flush_cnt", flush_cnt_o, 16'd0);
        nop(1'b0, 1'b0);
        chk("post_rst_stall", 16'(stall_id_o), 16'd0);

        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use clock clk (input, 1): all state updates on its rising edge.
REQ-002 The block SHALL use reset rst_n (input, 1): asynchronous, active-low.
REQ-003 id_valid_i  input  1: the decode stage holds a valid instruction.
REQ-004 id_rs1_i, id_rs2_i  input  5 each: source register indices of the decode-stage instruction.
REQ-005 id_use_rs1_i, id_use_rs2_i  input  1 each: the decode-stage instruction reads rs1 / rs2.
REQ-006 id_rd_i  input  5: destination register index of the decode-stage instruction.
REQ-007 id_wr_en_i  input  1: the decode-stage instruction writes rd.
REQ-008 id_is_load_i  input  1: the decode-stage instruction is a load.
REQ-009 br_taken_i  input  1: the instruction in EX is a taken branch or jump (redirect).
REQ-010 mem_busy_i  input  1: the data memory is not ready; the whole pipeline must freeze.
REQ-011 stall_if_o, stall_id_o  output  1 each: hold the fetch / decode pipeline registers.
REQ-012 flush_id_o  output  1: the decode register loads a NOP.
REQ-013 fwd_rs1_o, fwd_rs2_o  output  2 each: EX operand source; 00 = regfile, 01 = MEM-stage result, 10 = WB-stage result.
REQ-014 stall_cnt_o, flush_cnt_o  output  16 each: saturating performance counters.

Function
REQ-015 Internal tracking registers SHALL mirror the pipeline as follows:
  - EX: {valid, rd, wr, load, rs1, rs2, use1, use2}
  - MEM: {valid, rd, wr, load}
  - WB: {valid, rd, wr}
REQ-016 On each edge with mem_busy_i=0, the tracking registers SHALL advance: WB<=MEM, MEM<=EX, EX<=decode inputs; EX.valid <= id_valid_i & ~load_use & ~br_taken_i.
REQ-017 While mem_busy_i=1, all tracking registers SHALL hold.
REQ-018 While mem_busy_i=1, the outputs SHALL be: stall_if_o=1, stall_id_o=1, flush_id_o=0.
REQ-019 load_use SHALL be defined as: id_valid_i & EX.valid & EX.load & EX.wr & EX.rd!=0 & ((id_use_rs1_i & id_rs1_i==EX.rd) | (id_use_rs2_i & id_rs2_i==EX.rd)).
REQ-020 With mem_busy_i=0, load_use=1 and br_taken_i=0, the block SHALL drive stall_if_o=1, stall_id_o=1 and insert a bubble into EX; the stall lasts exactly 1 cycle.
REQ-021 With mem_busy_i=0 and br_taken_i=1, the block SHALL drive flush_id_o=1, stall_if_o=0, stall_id_o=0 and insert a bubble into EX; br_taken_i overrides load_use.
REQ-022 A branch that is taken while mem_busy_i=1 SHALL be flushed on the first cycle mem_busy_i=0; br_taken_i remains asserted while the branch is held in EX.
REQ-023 fwd_rs1_o SHALL be combinational from EX.rs1:
  - 01 if EX.valid & EX.use1 & MEM.valid & MEM.wr & ~MEM.load & MEM.rd==EX.rs1 & EX.rs1!=0;
  - else 10 if EX.valid & EX.use1 & WB.valid & WB.wr & WB.rd==EX.rs1 & EX.rs1!=0;
  - else 00.
  MEM has priority over WB.
REQ-024 fwd_rs2_o SHALL follow the REQ-023 rules, using EX.rs2 and EX.use2.
REQ-025 Register x0 SHALL never cause a stall or a forward.
REQ-026 The regfile is write-first; the block SHALL NOT detect WB-to-ID hazards.
REQ-027 stall_cnt_o SHALL increment by 1 on each edge where stall_id_o=1 (load-use or mem_busy), saturating at 16'hFFFF.
REQ-028 flush_cnt_o SHALL increment by 1 on each edge where flush_id_o=1, saturating at 16'hFFFF.

Reset
REQ-029 While rst_n=0, all tracking valid bits SHALL be 0 and all rd/rs fields SHALL be 0.
REQ-030 While rst_n=0, the outputs SHALL be: stall_if_o=0, stall_id_o=0, flush_id_o=0, fwd_rs1_o=00, fwd_rs2_o=00, stall_cnt_o=0, flush_cnt_o=0.
REQ-031 Reset asserted mid-stall or mid-freeze SHALL clear all state; the first edge after release SHALL behave as an empty pipeline.

Verification
REQ-032 Load-use: cycle 0 decode lw x5; cycle 1 decode add x6,x5,x7 -> stall_if_o=stall_id_o=1 for 1 cycle; add reaches EX with fwd_rs1_o=10; stall_cnt_o=1.
REQ-033 ALU forward: add x3,x1,x2 then sub x4,x3,x3 -> no stall; when sub is in EX, fwd_rs1_o=fwd_rs2_o=01. With one independent instruction between them -> both =10.
REQ-034 x0: lw x0 then add x1,x0,x0 -> no stall, fwd_rs1_o=fwd_rs2_o=00.
REQ-035 Branch vs load-use: br_taken_i=1 in the same cycle as a load_use condition -> flush_id_o=1, stall_id_o=0, EX bubble; flush_cnt_o=1.
REQ-036 Freeze: mem_busy_i=1 for 3 cycles with br_taken_i=1 -> stalls=1 and flush_id_o=0 for those 3 cycles, then flush_id_o=1 for one cycle; stall_cnt_o=3.
REQ-037 Saturation and reset: hold mem_busy_i=1 for 70000 cycles -> stall_cnt_o=16'hFFFF; pulse rst_n=0 mid-freeze -> all outputs 0 immediately.
